seq_detector_param: RTL and testbench

- Parametrised, runtime-programmable serial bit-pattern detector. Successor to the fixed 0110 Mealy overlapping detector `fsm`.
- Pattern length is 1..MAX_LEN. Overlap/non-overlap and Mealy/Moore output are selectable. Adds an input-valid qualifier and a saturating match counter.
- Sits on a serial bit stream inside control/protocol logic. Reset defaults reproduce the old 0110 overlapping Mealy behaviour.

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/seq_detector_param_if.sv | 33 +++
 rtl/seq_det_history.sv | 55 +++++
 rtl/seq_detector_param.sv | 72 +++++++
 tb/tb_seq_detector_param.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants, mode encodings and sizing helper for the serial pattern detector.
package seq_det_pkg;

    localparam logic [7:0] DEF_PATTERN_C = 8'b0000_0110;
    localparam int         DEF_LEN_C     = 4;

    typedef enum logic {
        NONOVERLAP = 1'b0,
        OVERLAP    = 1'b1
    } ovl_mode_e;

    typedef enum logic {
        MEALY = 1'b0,
        MOORE = 1'b1
    } out_mode_e;

    // Length field must hold MAX_LEN itself, hence the extra bit.
    function automatic int len_w(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Bit-stream, configuration and result signals of the pattern detector.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    import seq_det_pkg::*;

    localparam int LEN_W = len_w(MAX_LEN);

    // in_valid qualifies x for one cycle; there is no ready, the detector
    // consumes every valid bit. cfg_load is a single-cycle strobe that wins
    // over in_valid in the same cycle.
    logic               x;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cfg_moore;
    logic               z;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output x, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_moore,
        input  z, match_count
    );

    modport slave (
        input  x, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_moore,
        output z, match_count
    );

endinterface

// File: rtl/seq_det_history.sv
// Bit history, fill tracking and length-masked comparison producing the match strobe.
module seq_det_history #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_accept,
    input  logic               i_x,
    input  logic [MAX_LEN-1:0] i_pat,
    input  logic [LEN_W-1:0]   i_len,
    input  logic               i_nonovl,
    output logic               o_m
);

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;

    logic [MAX_LEN-1:0] w_win;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W:0]     w_fill_p1;
    logic               w_fill_ok;

    // Window bit k is the bit received k accepts before the current one.
    assign w_win     = {r_hist[MAX_LEN-2:0], i_x};
    assign w_fill_p1 = {1'b0, r_fill} + (LEN_W+1)'(1);
    assign w_fill_ok = (w_fill_p1 >= {1'b0, i_len});

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(i_len)) w_mask[i] = 1'b1;
        end
    end

    assign o_m = i_accept && (i_len != '0) && w_fill_ok &&
                 (((w_win ^ i_pat) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_accept) begin
            r_hist <= w_win;
            // Non-overlapping: bits up to and including the match are excluded.
            if (o_m && i_nonovl) begin
                r_fill <= '0;
            end else if (r_fill != LEN_W'(MAX_LEN)) begin
                r_fill <= r_fill + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector: config shadows, output mode and match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
    parameter int                 DEF_LEN     = DEF_LEN_C
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_detector_param_if.slave  bus
);

    localparam int               LEN_W      = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_CL = (DEF_LEN > MAX_LEN) ? LEN_W'(MAX_LEN)
                                                                  : LEN_W'(DEF_LEN);

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    ovl_mode_e          r_ovl;
    out_mode_e          r_moore;
    logic               r_zq;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_m;
    logic [LEN_W-1:0]   w_cfg_len;

    assign w_accept  = bus.in_valid && !bus.cfg_load && !reset;
    assign w_cfg_len = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;

    seq_det_history #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (bus.cfg_load),
        .i_accept (w_accept),
        .i_x      (bus.x),
        .i_pat    (r_pat),
        .i_len    (r_len),
        .i_nonovl (r_ovl == NONOVERLAP),
        .o_m      (w_m)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pat   <= DEF_PATTERN;
            r_len   <= DEF_LEN_CL;
            r_ovl   <= OVERLAP;
            r_moore <= MEALY;
            r_zq    <= 1'b0;
            r_cnt   <= '0;
        end else if (bus.cfg_load) begin
            r_pat   <= bus.cfg_pattern;
            r_len   <= w_cfg_len;
            r_ovl   <= ovl_mode_e'(bus.cfg_overlap);
            r_moore <= out_mode_e'(bus.cfg_moore);
            r_zq    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_zq <= w_m;
            if (w_m && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.z           = (r_moore == MOORE) ? r_zq : w_m;
    assign bus.match_count = r_cnt;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: reference model feeds an expected queue checked against two detector instances.
module tb_seq_detector_param;
    import seq_det_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_W2  = 2;
    localparam int LEN_W   = len_w(MAX_LEN);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W))  bus_a ();
    seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W2)) bus_b ();

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // ---------------- scoreboard state ----------------
    logic [10:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hits     = 0;

    logic [MAX_LEN-1:0] c_pat;
    logic [LEN_W-1:0]   c_len;
    logic               c_ovl, c_moore;

    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl, m_moore, m_zq;
    int                 m_cnt_a, m_cnt_b;
    bit                 acc_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pat = MAX_LEN'(DEF_PATTERN_C);
        m_len = DEF_LEN_C;
        m_ovl = 1'b1; m_moore = 1'b0; m_zq = 1'b0;
        m_cnt_a = 0; m_cnt_b = 0;
        acc_q.delete();
    endtask

    // ---------------- driver: one cycle, starting at a negedge ----------------
    task automatic drive(input bit rst, input bit load, input bit v, input bit xb);
        bit mm, ez, b;
        logic [10:0] e;
        reset = rst;
        bus_a.cfg_load = load; bus_b.cfg_load = load;
        bus_a.in_valid = v;    bus_b.in_valid = v;
        bus_a.x = xb;          bus_b.x = xb;
        bus_a.cfg_pattern = c_pat; bus_b.cfg_pattern = c_pat;
        bus_a.cfg_len = c_len;     bus_b.cfg_len = c_len;
        bus_a.cfg_overlap = c_ovl; bus_b.cfg_overlap = c_ovl;
        bus_a.cfg_moore = c_moore; bus_b.cfg_moore = c_moore;

        // Expected match: compare the last m_len received bits with the pattern.
        mm = 1'b0;
        if (!rst && !load && v && m_len != 0 && acc_q.size() + 1 >= m_len) begin
            mm = 1'b1;
            for (int k = 0; k < m_len; k++) begin
                b = (k == 0) ? xb : acc_q[acc_q.size() - k];
                if (b != m_pat[k]) mm = 1'b0;
            end
        end
        ez = m_moore ? m_zq : mm;
        exp_q.push_back({ez, 8'(m_cnt_a), 2'(m_cnt_b)});

        #1;
        e = exp_q.pop_front();
        check("z_a", 32'(bus_a.z), 32'(e[10]));
        check("z_b", 32'(bus_b.z), 32'(e[10]));
        check("cnt_a", 32'(bus_a.match_count), 32'(e[9:2]));
        check("cnt_b", 32'(bus_b.match_count), 32'(e[1:0]));
        if (bus_a.z === 1'b1) hits++;

        if (rst) begin
            model_reset();
        end else if (load) begin
            m_pat = c_pat;
            m_len = (int'(c_len) > MAX_LEN) ? MAX_LEN : int'(c_len);
            m_ovl = c_ovl; m_moore = c_moore; m_zq = 1'b0;
            m_cnt_a = 0; m_cnt_b = 0;
            acc_q.delete();
        end else begin
            m_zq = mm;
            if (v) begin
                acc_q.push_back(xb);
                if (acc_q.size() > MAX_LEN) void'(acc_q.pop_front());
                if (mm) begin
                    if (!m_ovl) acc_q.delete();
                    if (m_cnt_a < 255) m_cnt_a++;
                    if (m_cnt_b < 3)   m_cnt_b++;
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        logic [15:0] v_bits;
        v_bits = bits;
        for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b0, 1'b1, v_bits[i]);
    endtask

    task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                            input bit ovl, input bit moore);
        c_pat = pat; c_len = len; c_ovl = ovl; c_moore = moore;
        drive(1'b0, 1'b1, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
        hits = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'(($urandom_range(0, 1))));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        c_pat = '0; c_len = '0; c_ovl = 1'b0; c_moore = 1'b0;
        reset = 1'b1;
        bus_a.x = 0; bus_a.in_valid = 0; bus_a.cfg_load = 0;
        bus_b.x = 0; bus_b.in_valid = 0; bus_b.cfg_load = 0;
        bus_a.cfg_pattern = '0; bus_a.cfg_len = '0; bus_a.cfg_overlap = 0; bus_a.cfg_moore = 0;
        bus_b.cfg_pattern = '0; bus_b.cfg_len = '0; bus_b.cfg_overlap = 0; bus_b.cfg_moore = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        reset = 1'b0;
        #1;
        check("rst_z", 32'(bus_a.z), 0);
        check("rst_cnt", 32'(bus_a.match_count), 0);
        hits = 0;

        // Default 0110 overlapping Mealy
        send_bits(16'b0110110, 7);
        idle(1);
        check("t1_hits", hits, 2);
        check("t1_cnt", 32'(bus_a.match_count), 2);

        // Non-overlapping Moore
        load_cfg(8'b0000_0110, 4, 1'b0, 1'b1);
        send_bits(16'b0110110, 7);
        idle(2);
        check("t2_hits", hits, 1);
        check("t2_cnt", 32'(bus_a.match_count), 1);

        // Full-length pattern, overlap then non-overlap
        load_cfg(8'b1010_1010, 8, 1'b1, 1'b0);
        send_bits(16'b10_1010_1010, 10);
        check("t3_hits", hits, 2);
        check("t3_cnt", 32'(bus_a.match_count), 2);
        load_cfg(8'b1010_1010, 8, 1'b0, 1'b0);
        send_bits(16'b10_1010_1010, 10);
        check("t3n_hits", hits, 1);

        // Invalid cycles inside a pattern
        load_cfg(8'b0000_0110, 4, 1'b1, 1'b0);
        send_bits(16'b01, 2);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_nohit", hits, 0);
        send_bits(16'b10, 2);
        check("t4_hits", hits, 1);

        // Single-bit pattern, counter saturation on the narrow instance
        load_cfg(8'b0000_0001, 1, 1'b1, 1'b0);
        send_bits(16'b111111, 6);
        idle(1);
        check("t5_hits", hits, 6);
        check("t5_cnt_a", 32'(bus_a.match_count), 6);
        check("t5_cnt_b", 32'(bus_b.match_count), 3);

        // Restart mid-pattern via reset, then via cfg_load
        load_cfg(8'b0000_0110, 4, 1'b1, 1'b0);
        send_bits(16'b011, 3);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        send_bits(16'b0, 1);
        check("t6r_nohit", hits, 0);
        send_bits(16'b0110, 4);
        check("t6r_hits", hits, 1);
        load_cfg(8'b0000_0110, 4, 1'b1, 1'b0);
        send_bits(16'b011, 3);
        load_cfg(8'b0000_0110, 4, 1'b1, 1'b0);
        send_bits(16'b0, 1);
        check("t6l_nohit", hits, 0);
        send_bits(16'b0110, 4);
        check("t6l_hits", hits, 1);

        // len=0 disables matching
        load_cfg(8'b0000_0000, 0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b0, 1'(($urandom_range(0, 3) != 0)), 1'(($urandom_range(0, 1))));
        check("t7_hits", hits, 0);
        check("t7_cnt", 32'(bus_a.match_count), 0);

        // Oversized length clamps to MAX_LEN
        load_cfg(8'b1010_1010, 4'd12, 1'b1, 1'b0);
        send_bits(16'b10_1010_1010, 10);
        check("t8_hits", hits, 2);

        // Random configurations and streams, checked against the model
        for (int r = 0; r < 12; r++) begin
            load_cfg(MAX_LEN'($urandom_range(0, 255)), LEN_W'($urandom_range(1, 3)),
                     1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
            for (int i = 0; i < 60; i++)
                drive(1'b0, 1'b0, 1'(($urandom_range(0, 4) != 0)), 1'(($urandom_range(0, 1))));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
